// File: rtl/picomem_wb_bridge.sv
// PicoMem to Wishbone B4 classic bridge: one single transfer at a time, with a
// timeout and a sticky error flag so the CPU side always receives a completion.
module picomem_wb_bridge #(
    parameter logic [31:0] ADDR_MASK = 32'h3FFF_FFFF,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        mem_s_valid,
    output logic        mem_s_ready,
    input  logic [31:0] mem_s_addr,
    input  logic [31:0] mem_s_wdata,
    input  logic [3:0]  mem_s_wstrb,
    output logic [31:0] mem_s_rdata,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,

    output logic        bus_err,
    input  logic        err_clr
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cyc_d, stb_d, we_d, ready_d, err_d;
    logic [29:0]      adr_d;
    logic [3:0]       sel_d;
    logic [31:0]      dat_d, rdata_d;
    logic             err_ev_c;
    logic             fail_c;

    // Next-state and next-output logic; every registered output has a _d here.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cyc_d    = wb_cyc_o;
        stb_d    = wb_stb_o;
        we_d     = wb_we_o;
        adr_d    = wb_adr_o;
        sel_d    = wb_sel_o;
        dat_d    = wb_dat_o;
        ready_d  = 1'b0;
        rdata_d  = mem_s_rdata;
        err_d    = bus_err;
        err_ev_c = 1'b0;
        fail_c   = wb_err_i || (!wb_ack_i && (cnt_q == TO_LAST));

        case (state_q)
            S_IDLE: begin
                if (mem_s_valid) begin
                    state_d = S_BUS;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = |mem_s_wstrb;
                    adr_d   = 30'((mem_s_addr & ADDR_MASK) >> 2);
                    sel_d   = (|mem_s_wstrb) ? mem_s_wstrb : 4'hF;
                    dat_d   = mem_s_wdata;
                end
            end
            S_BUS: begin
                // Error and timeout share one path; a real err beats a same-cycle ack.
                if (fail_c) begin
                    err_ev_c = 1'b1;
                    rdata_d  = ERR_RDATA;
                end else if (wb_ack_i) begin
                    rdata_d  = wb_we_o ? 32'h0 : wb_dat_i;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                end
                if (fail_c || wb_ack_i) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (err_ev_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State and output registers; reset drops the bus without waiting for clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_sel_o    <= '0;
            wb_dat_o    <= '0;
            mem_s_ready <= 1'b0;
            mem_s_rdata <= '0;
            bus_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_cyc_o    <= cyc_d;
            wb_stb_o    <= stb_d;
            wb_we_o     <= we_d;
            wb_adr_o    <= adr_d;
            wb_sel_o    <= sel_d;
            wb_dat_o    <= dat_d;
            mem_s_ready <= ready_d;
            mem_s_rdata <= rdata_d;
            bus_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_picomem_wb_bridge.sv
// Directed bench for picomem_wb_bridge: a transaction-level reference model is
// checked every cycle, plus literal expectations for the key scenarios.
module tb_picomem_wb_bridge;

    localparam logic [31:0] MASK = 32'h3FFF_FFFF;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRV = 32'hFFFF_FFFF;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_s_valid, mem_s_ready;
    logic [31:0] mem_s_addr, mem_s_wdata, mem_s_rdata;
    logic [3:0]  mem_s_wstrb;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic        bus_err, err_clr;

    picomem_wb_bridge #(
        .ADDR_MASK(MASK),
        .TIMEOUT  (TO),
        .ERR_RDATA(ERRV)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_s_valid(mem_s_valid),
        .mem_s_ready(mem_s_ready),
        .mem_s_addr (mem_s_addr),
        .mem_s_wdata(mem_s_wdata),
        .mem_s_wstrb(mem_s_wstrb),
        .mem_s_rdata(mem_s_rdata),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .bus_err    (bus_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ready_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: m_bus = BUS cycles already spent (-1 = no transfer open).
    int          m_bus = -1;
    bit          m_rdy = 1'b0;
    bit          m_err = 1'b0;
    bit          m_we  = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [29:0] m_adr;
    logic [3:0]  m_sel;
    logic [31:0] m_dat;
    bit          nrdy, eset;

    always @(negedge clk) begin
        if (mem_s_ready === 1'b1) ready_pulses++;
        if (!resetn) begin
            m_bus = -1; m_rdy = 1'b0; m_err = 1'b0; m_we = 1'b0; m_rdata = 32'h0;
            chk("rst_cyc",   32'(wb_cyc_o),    32'h0);
            chk("rst_stb",   32'(wb_stb_o),    32'h0);
            chk("rst_we",    32'(wb_we_o),     32'h0);
            chk("rst_ready", 32'(mem_s_ready), 32'h0);
            chk("rst_err",   32'(bus_err),     32'h0);
            chk("rst_rdata", mem_s_rdata,      32'h0);
            chk("rst_adr",   32'(wb_adr_o),    32'h0);
            chk("rst_sel",   32'(wb_sel_o),    32'h0);
            chk("rst_dat",   wb_dat_o,         32'h0);
        end else begin
            chk("cyc",   32'(wb_cyc_o),    32'(m_bus >= 0));
            chk("stb",   32'(wb_stb_o),    32'(m_bus >= 0));
            chk("ready", 32'(mem_s_ready), 32'(m_rdy));
            chk("rdata", mem_s_rdata,      m_rdata);
            chk("err",   32'(bus_err),     32'(m_err));
            if (m_bus >= 0) begin
                chk("we",  32'(wb_we_o),  32'(m_we));
                chk("adr", 32'(wb_adr_o), 32'(m_adr));
                chk("sel", 32'(wb_sel_o), 32'(m_sel));
                chk("dat", wb_dat_o,      m_dat);
            end else begin
                chk("we_idle", 32'(wb_we_o), 32'h0);
            end
            // advance the model with the inputs the next edge will sample
            nrdy = 1'b0;
            eset = 1'b0;
            if (m_bus >= 0) begin
                if (wb_err_i || (!wb_ack_i && (m_bus + 1 >= TO))) begin
                    m_rdata = ERRV; eset = 1'b1; nrdy = 1'b1; m_bus = -1;
                end else if (wb_ack_i) begin
                    m_rdata = m_we ? 32'h0 : wb_dat_i; nrdy = 1'b1; m_bus = -1;
                end else begin
                    m_bus++;
                end
            end else if (!m_rdy && mem_s_valid) begin
                m_adr = 30'((mem_s_addr & MASK) >> 2);
                m_we  = |mem_s_wstrb;
                m_sel = m_we ? mem_s_wstrb : 4'hF;
                m_dat = mem_s_wdata;
                m_bus = 0;
            end
            if (eset) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_rdy = nrdy;
        end
    end

    // One PicoMem transfer with a scripted slave response; reports what it saw.
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input int wait_n, input int mode, input logic [31:0] rd,
                            input bit clr_at_resp, input bit hold_valid,
                            output int lat, output int cc, output logic [29:0] oadr,
                            output logic [3:0] osel, output logic owe, output logic [31:0] odat);
        int n;
        mem_s_valid = 1'b1; mem_s_addr = a; mem_s_wdata = wd; mem_s_wstrb = st;
        lat = 0; n = 0;
        do begin
            @(posedge clk); #1; lat++; n++;
        end while (!wb_cyc_o && n < 20);
        chk("cyc_start", 32'(wb_cyc_o), 32'h1);
        oadr = wb_adr_o; osel = wb_sel_o; owe = wb_we_o; odat = wb_dat_o; cc = 1;
        if (!hold_valid) mem_s_valid = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            @(posedge clk); #1; lat++; cc += int'(wb_cyc_o);
        end
        if (mode != M_SILENT) begin
            wb_ack_i = (mode == M_ACK) || (mode == M_BOTH);
            wb_err_i = (mode == M_ERR) || (mode == M_BOTH);
            wb_dat_i = rd;
            err_clr  = clr_at_resp;
        end
        n = 0;
        while (!mem_s_ready && n < 40) begin
            @(posedge clk); #1; lat++; n++; cc += int'(wb_cyc_o);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; err_clr = 1'b0;
        end
        chk("ready_seen", 32'(mem_s_ready), 32'h1);
        if (!hold_valid) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        int          lat, cc;
        logic [29:0] oadr;
        logic [3:0]  osel;
        logic        owe;
        logic [31:0] odat;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_data [3];

        resetn = 1'b0; mem_s_valid = 1'b0; mem_s_addr = 32'h0; mem_s_wdata = 32'h0;
        mem_s_wstrb = 4'h0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Read, zero wait, issued on the first cycle out of reset
        run_xfer(32'hC000_0010, 32'h0, 4'h0, 0, M_ACK, 32'h1234_5678, 1'b0, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("rd_adr",   32'(oadr),   32'h0000_0004);
        chk("rd_sel",   32'(osel),   32'hF);
        chk("rd_we",    32'(owe),    32'h0);
        chk("rd_lat",   32'(lat),    32'd2);
        chk("rd_rdata", mem_s_rdata, 32'h1234_5678);

        // Write, three wait states
        run_xfer(32'hC000_0020, 32'hA5A5_0000, 4'b1100, 3, M_ACK, 32'h7777_7777, 1'b0, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("wr_adr",   32'(oadr),   32'h0000_0008);
        chk("wr_sel",   32'(osel),   32'hC);
        chk("wr_we",    32'(owe),    32'h1);
        chk("wr_dat",   odat,        32'hA5A5_0000);
        chk("wr_cyc_n", 32'(cc),     32'd4);
        chk("wr_rdata", mem_s_rdata, 32'h0);

        // Timeout with a silent slave, then clear the sticky flag
        run_xfer(32'h0000_0100, 32'h0, 4'h0, 0, M_SILENT, 32'h0, 1'b0, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("to_cyc_n", 32'(cc),     32'd8);
        chk("to_rdata", mem_s_rdata, 32'hFFFF_FFFF);
        chk("to_err",   32'(bus_err), 32'h1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("clr_err",  32'(bus_err), 32'h0);

        // Read with waits; valid dropped while the bus cycle is open
        run_xfer(32'h4000_0044, 32'h0, 4'h0, 2, M_ACK, 32'hDEAD_BEEF, 1'b0, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("rw_adr",   32'(oadr),   32'h0000_0011);
        chk("rw_cyc_n", 32'(cc),     32'd3);
        chk("rw_rdata", mem_s_rdata, 32'hDEAD_BEEF);

        // err and ack together: error wins
        run_xfer(32'h0000_0008, 32'h0, 4'h0, 1, M_BOTH, 32'h0000_0055, 1'b0, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("both_rdata", mem_s_rdata, 32'hFFFF_FFFF);
        chk("both_err",   32'(bus_err), 32'h1);
        err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
        chk("both_clr",   32'(bus_err), 32'h0);

        // err_clr coincident with a new error: set wins
        run_xfer(32'h0000_0030, 32'h1111_2222, 4'b0011, 0, M_ERR, 32'h0, 1'b1, 1'b0,
                 lat, cc, oadr, osel, owe, odat);
        chk("clrset_err",   32'(bus_err), 32'h1);
        chk("clrset_rdata", mem_s_rdata,  32'hFFFF_FFFF);

        // Reset asserted mid-BUS drops the bus at once and yields no ready
        mem_s_valid = 1'b1; mem_s_addr = 32'h0000_0200; mem_s_wstrb = 4'h0;
        @(posedge clk); #1; mem_s_valid = 1'b0;
        @(posedge clk); #1;
        chk("prerst_cyc", 32'(wb_cyc_o), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("async_cyc",   32'(wb_cyc_o),    32'h0);
        chk("async_stb",   32'(wb_stb_o),    32'h0);
        chk("async_ready", 32'(mem_s_ready), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back reads with valid held high
        b2b_addr[0] = 32'h0000_1000; b2b_data[0] = 32'h0BAD_F00D;
        b2b_addr[1] = 32'h8000_1004; b2b_data[1] = 32'hCAFE_0001;
        b2b_addr[2] = 32'h0000_1008; b2b_data[2] = 32'h1357_9BDF;
        for (int k = 0; k < 3; k++) begin
            run_xfer(b2b_addr[k], 32'h0, 4'h0, k, M_ACK, b2b_data[k], 1'b0, 1'b1,
                     lat, cc, oadr, osel, owe, odat);
            chk("b2b_rdata", mem_s_rdata, b2b_data[k]);
        end
        mem_s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_total", 32'(ready_pulses), 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
